// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bundle: the instruction-memory request/response channel plus the
// decode-side head channel. Clock and reset stay outside the bundle.
interface ifu_fetch_queue_if;
    // Handshake rules. A request transfers on a rising edge where imem_req_valid
    // and imem_req_ready are both high. imem_req_valid never waits on
    // imem_req_ready. Responses return in request order, one per imem_resp_valid
    // cycle, and cannot be stalled. The head transfers to decode on an edge where
    // valid_o and ready_i are both high. The head fields are stable while valid_o
    // is high and ready_i is low.
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] snpc_o;
    logic [31:0] inst_o;
    logic [1:0]  excp_o;
    logic        ready_i;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output valid_o, pc_o, snpc_o, inst_o, excp_o,
        input  ready_i
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  valid_o, pc_o, snpc_o, inst_o, excp_o,
        output ready_i
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// In-order fetch unit. It keeps up to FQ_DEPTH memory requests in flight and
// buffers their results in a FIFO that feeds decode. Redirects flush the FIFO.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          FQ_DEPTH = 4,
    parameter int          CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              excp_flush,
    input  logic              xret_flush,
    input  logic [31:0]       csr_mtvec,
    input  logic [31:0]       csr_mepc,
    input  logic              branch_flush,
    input  logic [31:0]       branch_target,
    ifu_fetch_queue_if.master fq
);
    localparam int               PTR_W   = $clog2(FQ_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(FQ_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] iss_ptr_q, iss_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // The PC FIFO is written when a request issues. The data FIFO is written
    // when that request's response arrives. Responses return in order, so the
    // two FIFOs stay in step.
    logic [31:0] pc_mem_q   [FQ_DEPTH];
    logic [31:0] inst_mem_q [FQ_DEPTH];
    logic [1:0]  excp_mem_q [FQ_DEPTH];

    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] live;
    logic             room;
    logic             aligned;
    logic             req_valid;
    logic             req_fire;
    logic             misal_enq;
    logic             resp_drop;
    logic             resp_enq;
    logic             enq;
    logic             head_valid;
    logic             head_out;
    logic             deq;
    logic             pc_we;
    logic [31:0]      enq_inst;
    logic [1:0]       enq_excp;

    always_comb begin
        redirect    = excp_flush | xret_flush | branch_flush;
        redirect_pc = excp_flush ? csr_mtvec :
                      xret_flush ? csr_mepc  : branch_target;

        // live is the number of responses still owed that will be kept.
        live    = out_cnt_q - drop_cnt_q;
        room    = ({1'b0, live} + {1'b0, count_q}) < DEPTH_W;
        aligned = (fetch_pc_q[1:0] == 2'b00);

        req_valid = reset_n && !redirect && !halt_q && aligned && room;
        req_fire  = req_valid && fq.imem_req_ready;

        // A misaligned PC is enqueued only after all live responses have
        // returned. This keeps its entry in program order.
        misal_enq = reset_n && !redirect && !halt_q && !aligned &&
                    (live == '0) && (count_q < DEPTH_C);

        resp_drop = fq.imem_resp_valid && (drop_cnt_q != '0);
        resp_enq  = reset_n && !redirect && fq.imem_resp_valid && (drop_cnt_q == '0);
        enq       = resp_enq || misal_enq;
        pc_we     = req_fire || misal_enq;

        head_valid = (count_q != '0);
        head_out   = reset_n && !redirect && head_valid;
        deq        = head_out && fq.ready_i;

        enq_inst = '0;
        enq_excp = 2'b00;
        if (misal_enq) begin
            enq_excp = 2'b01;
        end else if (fq.imem_resp_err) begin
            enq_excp = 2'b10;
        end else begin
            enq_inst = fq.imem_resp_data;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halt_d     = halt_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        iss_ptr_d  = iss_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (redirect) begin
            // Every response still owed after this edge belongs to the old path.
            fetch_pc_d = redirect_pc;
            halt_d     = 1'b0;
            out_cnt_d  = out_cnt_q - CNT_W'(fq.imem_resp_valid);
            drop_cnt_d = out_cnt_q - CNT_W'(fq.imem_resp_valid);
            count_d    = '0;
            iss_ptr_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(fq.imem_resp_valid);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (misal_enq || (resp_enq && fq.imem_resp_err)) begin
                halt_d = 1'b1;
            end
            count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
            iss_ptr_d = iss_ptr_q + PTR_W'(pc_we);
            wr_ptr_d  = wr_ptr_q + PTR_W'(enq);
            rd_ptr_d  = rd_ptr_q + PTR_W'(deq);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            halt_q     <= 1'b0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            iss_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halt_q     <= halt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            iss_ptr_q  <= iss_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // The storage arrays have no reset. Their outputs are masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (pc_we) begin
            pc_mem_q[iss_ptr_q] <= fetch_pc_q;
        end
        if (enq) begin
            inst_mem_q[wr_ptr_q] <= enq_inst;
            excp_mem_q[wr_ptr_q] <= enq_excp;
        end
    end

    always_comb begin
        fq.imem_req_valid = req_valid;
        fq.imem_req_addr  = {fetch_pc_q[31:2], 2'b00};
        fq.valid_o        = head_out;
        fq.pc_o           = head_valid ? pc_mem_q[rd_ptr_q] : '0;
        fq.snpc_o         = head_valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : '0;
        fq.inst_o         = head_valid ? inst_mem_q[rd_ptr_q] : '0;
        fq.excp_o         = head_valid ? excp_mem_q[rd_ptr_q] : 2'b00;
    end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: an in-order memory model with random latency,
// random decode backpressure and redirects, checked against a reference stream.
module tb_ifu_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          CNT_W = $clog2(DEPTH) + 1;
    localparam int          CAP   = (1 << CNT_W) - 1;
    localparam logic [31:0] RPC   = 32'h3000_0000;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        int          seg;
        int          due;
    } pend_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        excp_flush = 1'b0, xret_flush = 1'b0, branch_flush = 1'b0;
    logic [31:0] csr_mtvec = '0, csr_mepc = '0, branch_target = '0;

    ifu_fetch_queue_if fq();

    ifu_fetch_queue #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .excp_flush    (excp_flush),
        .xret_flush    (xret_flush),
        .csr_mtvec     (csr_mtvec),
        .csr_mepc      (csr_mepc),
        .branch_flush  (branch_flush),
        .branch_target (branch_target),
        .fq            (fq)
    );

    always #5 clock = ~clock;

    int          errors = 0, checks = 0, cyc = 0, seg = 0;
    logic [65:0] exp_q[$];
    pend_t       pend[$];
    logic [31:0] model_pc = RPC;
    bit          model_halt = 0;
    logic [31:0] err_addr = 32'h1;
    int          rdy_pct = 100, req_pct = 100, resp_pct = 100, min_lat = 1, max_lat = 1;
    bit          mem_hold = 0, rst_ctl = 0;
    bit          fl_e = 0, fl_x = 0, fl_b = 0;
    logic [31:0] t_mtvec = '0, t_mepc = '0, t_br = '0;
    int          fire_cnt = 0, first_fire = -1, first_valid = -1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] a;
        a = $urandom;
        a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return a;
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle. Inputs are driven on the falling edge. Outputs are
    // sampled 1 time unit later, and the reference model advances on what
    // will transfer at the next rising edge.
    task automatic cycle();
        pend_t p;
        bit    resp_now, fire, redir;
        @(negedge clock);
        reset_n  = rst_ctl;
        resp_now = 0;
        fq.ready_i = ($urandom_range(0, 99) < rdy_pct);
        if (reset_n && !mem_hold && pend.size() > 0 && pend[0].due <= cyc &&
            $urandom_range(0, 99) < resp_pct) begin
            p = pend.pop_front();
            resp_now = 1;
            fq.imem_resp_valid = 1'b1;
            fq.imem_resp_data  = mem_data(p.addr);
            fq.imem_resp_err   = p.err;
        end else begin
            fq.imem_resp_valid = 1'b0;
            fq.imem_resp_data  = $urandom;
            fq.imem_resp_err   = 1'($urandom_range(0, 1));
        end
        fq.imem_req_ready = (pend.size() < CAP) && ($urandom_range(0, 99) < req_pct);
        excp_flush = fl_e; xret_flush = fl_x; branch_flush = fl_b;
        csr_mtvec = t_mtvec; csr_mepc = t_mepc; branch_target = t_br;
        #1;
        redir = fl_e | fl_x | fl_b;
        fire  = fq.imem_req_valid && fq.imem_req_ready;
        if (fq.valid_o && first_valid < 0) first_valid = cyc;
        if (!reset_n) begin
            pend.delete(); exp_q.delete(); seg++;
            model_pc = RPC; model_halt = 0;
        end else if (redir) begin
            chk("redirect_quiet", 66'({fq.imem_req_valid, fq.valid_o}), 66'd0);
            seg++; exp_q.delete();
            model_pc = fl_e ? t_mtvec : (fl_x ? t_mepc : t_br);
            model_halt = 0;
            if (model_pc[1:0] != 2'b00) begin
                exp_q.push_back({model_pc, 32'h0, 2'b01});
                model_halt = 1;
            end
        end else begin
            if (model_halt) chk("halt_no_req", 66'(fq.imem_req_valid), 66'd0);
            if (fire) begin
                fire_cnt++;
                if (first_fire < 0) first_fire = cyc;
                chk("req_addr", 66'(fq.imem_req_addr), 66'(model_pc));
                pend.push_back('{addr: fq.imem_req_addr, err: (fq.imem_req_addr == err_addr),
                                 seg: seg, due: cyc + $urandom_range(min_lat, max_lat)});
                if (model_pc == err_addr) exp_q.push_back({model_pc, 32'h0, 2'b10});
                else exp_q.push_back({model_pc, mem_data(model_pc), 2'b00});
                model_pc += 32'd4;
            end
            if (resp_now && p.seg == seg && p.err) model_halt = 1;
        end
        fl_e = 0; fl_x = 0; fl_b = 0;
        cyc++;
    endtask

    task automatic do_reset();
        rst_ctl = 0;
        repeat (3) cycle();
        chk("reset_valid_o", 66'(fq.valid_o), 66'd0);
        chk("reset_req_valid", 66'(fq.imem_req_valid), 66'd0);
        chk("reset_excp_o", 66'(fq.excp_o), 66'd0);
        rst_ctl = 1;
        fire_cnt = 0; first_fire = -1; first_valid = -1;
    endtask

    // Scoreboard: on each head transfer, pop the oldest expected entry and compare.
    always @(negedge clock) begin : monitor
        logic [65:0] e;
        #2;
        if (reset_n && fq.valid_o && fq.ready_i) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL deq_unexpected: actual pc=%0h required=no entry (cycle %0d)", fq.pc_o, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("deq_pc", 66'(fq.pc_o), 66'(e[65:34]));
                chk("deq_snpc", 66'(fq.snpc_o), 66'(e[65:34] + 32'd4));
                chk("deq_inst", 66'(fq.inst_o), 66'(e[33:2]));
                chk("deq_excp", 66'(fq.excp_o), 66'(e[1:0]));
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        int          n;
        fq.ready_i = 0; fq.imem_req_ready = 0;
        fq.imem_resp_valid = 0; fq.imem_resp_data = '0; fq.imem_resp_err = 0;

        // Back-to-back issue and the first-entry latency.
        rdy_pct = 100; req_pct = 100; resp_pct = 100; min_lat = 1; max_lat = 1;
        do_reset();
        repeat (3) cycle();
        chk("t1_back_to_back", 66'(fire_cnt), 66'd3);
        repeat (5) cycle();
        chk("t1_first_valid_latency", 66'(first_valid - first_fire), 66'd2);

        // With decode stalled, issue stops at the credit limit.
        rdy_pct = 0;
        do_reset();
        repeat (12) cycle();
        chk("t2_credit_limit", 66'(fire_cnt), 66'(DEPTH));
        chk("t2_req_blocked", 66'(fq.imem_req_valid), 66'd0);
        rdy_pct = 100;
        repeat (4) cycle();
        chk("t2_resume", 66'(fire_cnt > DEPTH), 66'd1);

        // Three requests in flight are dropped by a branch redirect.
        mem_hold = 1;
        do_reset();
        repeat (3) cycle();
        chk("t3_inflight", 66'(fire_cnt), 66'd3);
        t_br = 32'h8000_0000; fl_b = 1;
        cycle();
        mem_hold = 0;
        repeat (15) cycle();

        // All three flushes together: the exception target wins.
        t_mtvec = 32'h0000_1000; t_mepc = 32'h0000_2000; t_br = 32'h0000_3000;
        fl_e = 1; fl_x = 1; fl_b = 1;
        cycle();
        repeat (15) cycle();

        // Misaligned branch target: one faulting entry, then fetch halts.
        t_br = 32'h8000_0002; fl_b = 1;
        cycle();
        repeat (10) cycle();
        chk("t5_single_entry", 66'(exp_q.size()), 66'd0);
        chk("t5_halted", 66'(fq.imem_req_valid), 66'd0);

        // Access fault at 0x30000008. Younger requests still in flight arrive behind it.
        err_addr = 32'h3000_0008; min_lat = 2; max_lat = 2;
        do_reset();
        repeat (20) cycle();
        chk("t6_inflight_after_err", 66'(fire_cnt >= 4), 66'd1);
        chk("t6_drained", 66'(exp_q.size()), 66'd0);
        chk("t6_halted", 66'(fq.imem_req_valid), 66'd0);

        // Random segments: random flush mix, targets, faults, latency and backpressure.
        for (int s = 0; s < 40; s++) begin
            rdy_pct  = $urandom_range(30, 100);
            req_pct  = $urandom_range(30, 100);
            resp_pct = $urandom_range(40, 100);
            min_lat  = 1;
            max_lat  = $urandom_range(1, 3);
            t_mtvec = rand_target(); t_mepc = rand_target(); t_br = rand_target();
            fl_e = ($urandom_range(0, 3) == 0);
            fl_x = ($urandom_range(0, 3) == 0);
            fl_b = ($urandom_range(0, 1) == 0);
            if (!fl_e && !fl_x) fl_b = 1;
            tgt = fl_e ? t_mtvec : (fl_x ? t_mepc : t_br);
            err_addr = ($urandom_range(0, 1) == 1) ? tgt + 32'(4 * $urandom_range(0, 10)) : 32'h1;
            cycle();
            n = $urandom_range(10, 60);
            repeat (n) cycle();
        end

        // Drain: stop issuing and require every issued fetch to reach decode.
        rdy_pct = 100; req_pct = 0; resp_pct = 100; max_lat = 1;
        for (int i = 0; i < 200; i++) begin
            if (pend.size() == 0 && exp_q.size() == 0) break;
            cycle();
        end
        chk("drain_empty", 66'(exp_q.size()), 66'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
